wireframe_draw: RTL and testbench
=================================

Name: wireframe_draw

Overview:
- Upstream neighbour of the colour-fill stage (colorloop).
- Rasterises the three edges of one Triangle3D into the 1-bit wireframe SRAM, which the fill stage later reads through sram_val.
- Uses an integer Bresenham walker, all octants, one pixel per clock; the z component is ignored.
- Handshake mirrors the fill stage: level start, one-cycle done pulse.

Parameters:
IMG_W, `WIDTH, image width in pixels; also the row stride of the address.
IMG_H, `HEIGHT, image height in pixels.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ver  in  Triangle3D  vertices p,q,r; x/y are signed 16-bit; latched on start
draw_en  in  1  start request (level)
busy  out  1  high from start acceptance through done
done  out  1  one-cycle pulse, triangle complete
sram_addr  out  `WIREFRAME_ADDR_SIZE  pixel address = y*IMG_W + x
write_en  out  1  write strobe for wireframe SRAM
data_out  out  1  bit to write (1 = edge pixel)

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, write_en=0, data_out=0, sram_addr=0; armed=1. Reset mid-operation aborts with no done pulse.
- States: IDLE -> LATCH -> SETUP -> STEP -> (SETUP for next edge | DONE) -> IDLE.
- IDLE: when draw_en=1 and armed=1, go to LATCH.
  - armed clears on acceptance.
  - armed sets only when draw_en is sampled 0. A held draw_en therefore never retriggers.
- LATCH: register p,q,r; busy=1; edge index=0.
- SETUP, one cycle per edge. Edges are p->q, q->r, r->p.
  - Compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy.
  - Use 17-bit signed arithmetic; err is 18-bit signed.
- STEP, one pixel per cycle:
  - Drive sram_addr for (x,y) with data_out=1.
  - write_en=1 only if 0<=x<IMG_W and 0<=y<IMG_H. Out-of-range pixels are still stepped but not written (clipping).
  - Reaching the endpoint: write it, then go to SETUP for the next edge, or DONE after the third edge.
  - Update rule: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both may apply in the same cycle.
- Shared vertices are written once per edge touching them (duplicate writes are allowed). A fully degenerate triangle produces 3 writes to the same address.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, write_en=0; then IDLE.
- Latency:
  - draw_en sampled at edge N gives the first write at N+3 (LATCH, SETUP, first STEP).
  - Total cycles = 1 + 3 + Σ(max(|dx|,|dy|)+1) + 1.
- Outputs are registered. write_en, sram_addr and data_out change together on the clock edge.
- ver changes while busy=1 are ignored.

Optional Feature:
- Macro: WIREFRAME_CLEAR_EN.
- Defined:
  - A CLEAR state is inserted between LATCH and the first SETUP.
  - It writes data_out=0 to addresses 0..IMG_W*IMG_H-1, one per cycle with write_en=1, then proceeds.
  - Clearing adds IMG_W*IMG_H cycles.
- Undefined: no CLEAR state. The SRAM is not cleared, and the caller must clear it between triangles.

Test Plan:
- Bench uses IMG_W=16, IMG_H=8, feature off unless stated.
1. Right triangle p(0,0) q(0,7) r(15,7) -> writes in this order, then done one cycle later with busy=0:
   - p->q: addrs 0,16,...,112 (8 writes).
   - q->r: 112..127 (16 writes).
   - r->p: 16 diagonal writes ending at 0 (40 total).
2. Degenerate: all vertices (3,2) -> exactly 3 writes to addr 35, data_out=1, done after 3 STEP cycles.
3. Clipping: p(-2,0) q(2,0) r(2,0) -> 11 STEP cycles, 7 writes (addrs 0,1,2,2,2,1,0), no write for x<0.
4. Reset mid-edge: assert rst during the 5th STEP of case 1 -> write_en/busy/done/sram_addr go 0 immediately (asynchronously); next draw_en starts cleanly from p.
5. Re-arm: hold draw_en=1 through and 10 cycles past done -> no second run. Drop then raise draw_en -> new run begins.
6. WIREFRAME_CLEAR_EN defined with case 1 -> first 128 writes are data_out=0 to addrs 0..127 in order, then the 40 edge writes of case 1.

Source files
------------

// File: rtl/wireframe_draw.sv
// -----------------------------------------------------------------------------
// wireframe_draw
//
// Rasterises the three edges (p->q, q->r, r->p) of one triangle into a 1-bit
// wireframe SRAM using an integer Bresenham walker, one pixel per clock, all
// octants. The z components of the vertices are ignored. The colour-fill
// stage downstream later reads the same SRAM.
//
// Handshake: i_draw_en is a level request. A run is accepted only in IDLE
// while the block is armed. Acceptance disarms it, and it re-arms only after
// i_draw_en has been sampled low, so a held request never retriggers.
// o_busy is high from acceptance until the DONE cycle. o_done is a one-cycle
// pulse in that DONE cycle, and o_busy is already low in that same cycle.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous active-high reset (aborts a run, no o_done)
//   i_ver        triangle vertices p,q,r (signed 16-bit x/y), captured on
//                acceptance
//   i_draw_en    start request (level)
//   o_busy       run in progress
//   o_done       one-cycle completion pulse
//   o_sram_addr  pixel address y*IMG_W + x
//   o_write_en   SRAM write strobe (low for pixels outside the image)
//   o_data_out   bit to write (1 = edge pixel, 0 = clear)
//   o_dbg_state  current FSM state, for observation only
//
// Optional feature: define WIREFRAME_CLEAR_EN to insert a CLEAR state that
// writes 0 to every pixel address, in ascending order, before the first edge.
// -----------------------------------------------------------------------------
package wireframe_pkg;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } point3d_t;

  typedef struct packed {
    point3d_t p;
    point3d_t q;
    point3d_t r;
  } triangle3d_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_CLEAR = 3'd2,
    ST_SETUP = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;
endpackage

module wireframe_draw
  import wireframe_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  triangle3d_t       i_ver,
  input  logic              i_draw_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_write_en,
  output logic              o_data_out,
  output state_t            o_dbg_state
);

  localparam logic signed [16:0] W_S = 17'(IMG_W);
  localparam logic signed [16:0] H_S = 17'(IMG_H);
  localparam logic [ADDR_W-1:0]  W_A = ADDR_W'(IMG_W);

  // FSM and control
  state_t r_state;
  state_t w_state_nxt;
  logic   r_armed;
  logic   w_accept;

  // Captured vertices
  logic signed [15:0] r_px, r_py, r_qx, r_qy, r_rx, r_ry;
  logic [1:0]         r_edge;

  // Bresenham walker
  logic signed [16:0] r_x, r_y, r_xe, r_ye, r_dx, r_dy;
  logic               r_sx_neg, r_sy_neg;
  logic signed [17:0] r_err;

  // Registered outputs
  logic              r_busy, r_done, r_we, r_data;
  logic [ADDR_W-1:0] r_addr;

  // Next-value nets
  logic signed [16:0] w_x_nxt, w_y_nxt;
  logic signed [17:0] w_err_nxt;
  logic              w_busy_nxt, w_done_nxt, w_we_nxt, w_data_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_pix_addr;

`ifdef WIREFRAME_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  logic [ADDR_W-1:0] r_clr;
  logic [ADDR_W-1:0] w_clr_nxt;
  // The counter register always holds the address currently being cleared.
  assign w_clr_nxt = (r_state == ST_CLEAR) ? r_clr + ADDR_W'(1) : '0;
`endif

  // z is carried by the triangle type but plays no part in a 2D wireframe.
  logic w_unused_z;
  assign w_unused_z = ^{i_ver.p.z, i_ver.q.z, i_ver.r.z};

  assign w_accept = (r_state == ST_IDLE) && i_draw_en && r_armed;

  // ---------------------------------------------------------------------------
  // Edge endpoint selection: edge 0 = p->q, 1 = q->r, 2 = r->p
  // ---------------------------------------------------------------------------
  logic signed [15:0] w_ax, w_ay, w_bx, w_by;
  always_comb begin
    w_ax = r_px;
    w_ay = r_py;
    w_bx = r_qx;
    w_by = r_qy;
    case (r_edge)
      2'd1: begin
        w_ax = r_qx; w_ay = r_qy; w_bx = r_rx; w_by = r_ry;
      end
      2'd2: begin
        w_ax = r_rx; w_ay = r_ry; w_bx = r_px; w_by = r_py;
      end
      default: ;
    endcase
  end

  // Setup arithmetic in 17 bits so the widest span (+-65535) never overflows.
  logic signed [16:0] w_x0, w_y0, w_x1, w_y1, w_ddx, w_ddy, w_adx, w_ady;
  assign w_x0  = {w_ax[15], w_ax};
  assign w_y0  = {w_ay[15], w_ay};
  assign w_x1  = {w_bx[15], w_bx};
  assign w_y1  = {w_by[15], w_by};
  assign w_ddx = w_x1 - w_x0;
  assign w_ddy = w_y1 - w_y0;
  assign w_adx = w_ddx[16] ? -w_ddx : w_ddx;
  assign w_ady = w_ddy[16] ? -w_ddy : w_ddy;

  // Step decision: e2 = 2*err compared against dy (<= 0) and dx (>= 0).
  logic signed [18:0] w_e2, w_dx19, w_dy19;
  logic signed [17:0] w_dx18, w_dy18;
  logic               w_step_x, w_step_y, w_at_end;
  assign w_e2     = {r_err, 1'b0};
  assign w_dx19   = {{2{r_dx[16]}}, r_dx};
  assign w_dy19   = {{2{r_dy[16]}}, r_dy};
  assign w_dx18   = {r_dx[16], r_dx};
  assign w_dy18   = {r_dy[16], r_dy};
  assign w_step_x = (w_e2 >= w_dy19);
  assign w_step_y = (w_e2 <= w_dx19);
  assign w_at_end = (r_x == r_xe) && (r_y == r_ye);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_LATCH;
`ifdef WIREFRAME_CLEAR_EN
      ST_LATCH: w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_clr == CLR_LAST) w_state_nxt = ST_SETUP;
`else
      ST_LATCH: w_state_nxt = ST_SETUP;
`endif
      ST_SETUP: w_state_nxt = ST_STEP;
      ST_STEP:  if (w_at_end) w_state_nxt = (r_edge == 2'd2) ? ST_DONE : ST_SETUP;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Walker next values (SETUP loads the start point, STEP advances it)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_err_nxt = r_err;
    if (r_state == ST_SETUP) begin
      w_x_nxt   = w_x0;
      w_y_nxt   = w_y0;
      w_err_nxt = {w_adx[16], w_adx} - {w_ady[16], w_ady};
    end else if (r_state == ST_STEP && !w_at_end) begin
      if (w_step_x) w_x_nxt = r_sx_neg ? r_x - 17'sd1 : r_x + 17'sd1;
      if (w_step_y) w_y_nxt = r_sy_neg ? r_y - 17'sd1 : r_y + 17'sd1;
      case ({w_step_x, w_step_y})
        2'b10:   w_err_nxt = r_err + w_dy18;
        2'b01:   w_err_nxt = r_err + w_dx18;
        2'b11:   w_err_nxt = r_err + w_dx18 + w_dy18;
        default: ;
      endcase
    end
  end

  // Modular arithmetic in ADDR_W bits yields the exact low bits of y*W+x.
  assign w_pix_addr = ADDR_W'(w_y_nxt) * W_A + ADDR_W'(w_x_nxt);

  // ---------------------------------------------------------------------------
  // FSM: output logic. Outputs are decoded from the next state and next pixel
  // and then registered, so they change together on the clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_we_nxt   = 1'b0;
    w_data_nxt = 1'b0;
    w_addr_nxt = '0;
    case (w_state_nxt)
      ST_LATCH, ST_SETUP: w_busy_nxt = 1'b1;
`ifdef WIREFRAME_CLEAR_EN
      ST_CLEAR: begin
        w_busy_nxt = 1'b1;
        w_we_nxt   = 1'b1;
        w_addr_nxt = w_clr_nxt;
      end
`endif
      ST_STEP: begin
        w_busy_nxt = 1'b1;
        w_data_nxt = 1'b1;
        w_addr_nxt = w_pix_addr;
        // Off-image pixels are still walked but never written.
        w_we_nxt   = (w_x_nxt >= 17'sd0) && (w_x_nxt < W_S) &&
                     (w_y_nxt >= 17'sd0) && (w_y_nxt < H_S);
      end
      ST_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_armed  <= 1'b1;
      r_px     <= '0; r_py <= '0; r_qx <= '0; r_qy <= '0; r_rx <= '0; r_ry <= '0;
      r_edge   <= '0;
      r_x      <= '0; r_y  <= '0; r_xe <= '0; r_ye <= '0;
      r_dx     <= '0; r_dy <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_err    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_data   <= 1'b0;
      r_addr   <= '0;
    end else begin
      if (!i_draw_en)    r_armed <= 1'b1;
      else if (w_accept) r_armed <= 1'b0;

      // Vertices are captured on the accepting edge, so any later change of
      // i_ver (busy already high) cannot affect the run.
      if (w_accept) begin
        r_px <= i_ver.p.x; r_py <= i_ver.p.y;
        r_qx <= i_ver.q.x; r_qy <= i_ver.q.y;
        r_rx <= i_ver.r.x; r_ry <= i_ver.r.y;
      end

      if (r_state == ST_LATCH) r_edge <= 2'd0;
      if (r_state == ST_STEP && w_at_end) r_edge <= r_edge + 2'd1;

      if (r_state == ST_SETUP) begin
        r_xe     <= w_x1;
        r_ye     <= w_y1;
        r_dx     <= w_adx;
        r_dy     <= -w_ady;
        r_sx_neg <= w_ddx[16];
        r_sy_neg <= w_ddy[16];
      end

      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_err  <= w_err_nxt;

      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_we   <= w_we_nxt;
      r_data <= w_data_nxt;
      r_addr <= w_addr_nxt;
    end
  end

`ifdef WIREFRAME_CLEAR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_clr <= '0;
    else       r_clr <= w_clr_nxt;
  end
`endif

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_write_en  = r_we;
  assign o_data_out  = r_data;
  assign o_sram_addr = r_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wireframe_draw.sv
// -----------------------------------------------------------------------------
// tb_wireframe_draw
//
// Directed bench for wireframe_draw at IMG_W=16, IMG_H=8. Expected SRAM
// writes ({data, addr}) are queued as each triangle is launched and are popped
// by a negedge monitor whenever the DUT strobes write_en. Run-level timing
// (first-write latency, total cycles, done pulse) is checked per triangle.
// -----------------------------------------------------------------------------
module tb_wireframe_draw;
  import wireframe_pkg::*;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 7;
`ifdef WIREFRAME_CLEAR_EN
  localparam int CLR = W * H;
`else
  localparam int CLR = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  triangle3d_t   ver;
  logic          draw_en;
  logic          busy, done, write_en, data_out;
  logic [AW-1:0] sram_addr;
  state_t        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  wireframe_draw #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ver       (ver),
    .i_draw_en   (draw_en),
    .o_busy      (busy),
    .o_done      (done),
    .o_sram_addr (sram_addr),
    .o_write_en  (write_en),
    .o_data_out  (data_out),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [AW:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && write_en) begin
      wr_cnt++;
      if (exp_q.size() == 0)
        chk("sb_unexpected_write", 32'({data_out, sram_addr}), 32'hFFFF_FFFF);
      else
        chk("sb_write", 32'({data_out, sram_addr}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / reference tasks
  // ---------------------------------------------------------------------------
  task automatic set_ver(input int px, input int py, input int qx, input int qy,
                         input int rx, input int ry);
    ver.p.x = 16'(px); ver.p.y = 16'(py); ver.p.z = 16'($urandom);
    ver.q.x = 16'(qx); ver.q.y = 16'(qy); ver.q.z = 16'($urandom);
    ver.r.x = 16'(rx); ver.r.y = 16'(ry); ver.r.z = 16'($urandom);
  endtask

  task automatic push_clear();
    for (int a = 0; a < CLR; a++) exp_q.push_back({1'b0, AW'(a)});
  endtask

  // Textbook integer Bresenham; queues every on-image pixel of one edge.
  task automatic model_edge(input int x0, input int y0, input int x1, input int y1,
                            inout int steps, inout int writes);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int n = 0; n < 1000; n++) begin
      steps++;
      if (x >= 0 && x < W && y >= 0 && y < H) begin
        exp_q.push_back({1'b1, AW'(y * W + x)});
        writes++;
      end
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic push_model_tri(input int px, input int py, input int qx, input int qy,
                                input int rx, input int ry,
                                output int steps, output int writes);
    steps  = 0;
    writes = 0;
    model_edge(px, py, qx, qy, steps, writes);
    model_edge(qx, qy, rx, ry, steps, writes);
    model_edge(rx, ry, px, py, steps, writes);
  endtask

  // Raises draw_en (left high on return) and checks one complete run.
  // first_off < 0 skips the first-write latency check.
  task automatic run_tri(input string tag, input int exp_writes, input int exp_steps,
                         input int first_off);
    int s, w0, fw;
    bit seen_d;
    @(negedge clk);
    draw_en = 1'b1;
    s       = cyc;
    w0      = wr_cnt;
    fw      = -1;
    seen_d  = 1'b0;
    for (int t = 0; t < 4000 && !seen_d; t++) begin
      @(negedge clk);
      if (write_en && fw < 0) fw = cyc;
      if (done) seen_d = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen_d), 32'd1);
    if (seen_d) begin
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_we_at_done"}, 32'(write_en), 32'd0);
      chk({tag, "_cycles"}, 32'(cyc - s), 32'(5 + exp_steps + CLR));
      chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_writes + CLR));
      if (first_off >= 0)
        chk({tag, "_first_write"}, 32'(fw - s), 32'((CLR > 0) ? 2 : first_off));
      chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int st, wr, w0, pts[6];
    bit bs;

    rst     = 1'b1;
    draw_en = 1'b0;
    set_ver(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_we", 32'(write_en), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Right triangle: 8 + 16 + 16 writes, all on-image.
    set_ver(0, 0, 0, 7, 15, 7);
    push_clear();
    push_model_tri(0, 0, 0, 7, 15, 7, st, wr);
    run_tri("right_tri", 40, 40, 3);

    // draw_en still high: no retrigger for 10 cycles.
    w0 = wr_cnt;
    bs = 1'b0;
    repeat (10) begin
      @(negedge clk);
      bs |= busy;
    end
    chk("rearm_held_busy", 32'(bs), 32'd0);
    chk("rearm_held_writes", 32'(wr_cnt - w0), 32'd0);

    // Drop then raise: a fresh run (degenerate triangle) begins.
    draw_en = 1'b0;
    set_ver(3, 2, 3, 2, 3, 2);
    push_clear();
    repeat (3) exp_q.push_back({1'b1, 7'd35});
    run_tri("degenerate", 3, 3, 3);

    // Clipping: x<0 pixels are walked but not written.
    draw_en = 1'b0;
    set_ver(-2, 0, 2, 0, 2, 0);
    push_clear();
    exp_q.push_back({1'b1, 7'd0}); exp_q.push_back({1'b1, 7'd1});
    exp_q.push_back({1'b1, 7'd2}); exp_q.push_back({1'b1, 7'd2});
    exp_q.push_back({1'b1, 7'd2}); exp_q.push_back({1'b1, 7'd1});
    exp_q.push_back({1'b1, 7'd0});
    run_tri("clip", 7, 11, 5);

    // Reset during the 5th STEP of the right triangle.
    draw_en = 1'b0;
    @(negedge clk);
    set_ver(0, 0, 0, 7, 15, 7);
    push_clear();
    push_model_tri(0, 0, 0, 7, 15, 7, st, wr);
    @(negedge clk);
    draw_en = 1'b1;
    w0 = wr_cnt;
    for (int t = 0; t < 1000 && (wr_cnt - w0) < 5 + CLR; t++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_fifth_step", 32'(wr_cnt - w0), 32'(5 + CLR));
    chk("abort_we_before", 32'(write_en), 32'd1);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst     = 1'b1;
    draw_en = 1'b0;
    #1;
    chk("abort_we", 32'(write_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_clear();
    push_model_tri(0, 0, 0, 7, 15, 7, st, wr);
    run_tri("after_abort", 40, 40, 3);

    // Random triangles straddling the image border.
    for (int k = 0; k < 4; k++) begin
      draw_en = 1'b0;
      for (int j = 0; j < 6; j += 2) begin
        pts[j]     = int'($urandom_range(0, 23)) - 4;
        pts[j + 1] = int'($urandom_range(0, 13)) - 3;
      end
      set_ver(pts[0], pts[1], pts[2], pts[3], pts[4], pts[5]);
      push_clear();
      push_model_tri(pts[0], pts[1], pts[2], pts[3], pts[4], pts[5], st, wr);
      run_tri($sformatf("rand%0d", k), wr, st, -1);
    end

    draw_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
